// File: rtl/vending_controller.sv
// vending_controller: coin balance, item dispense and greedy change-return sequencer
module vending_controller #(
  parameter int TOTAL_BITS = 31,
  parameter int NUM_ITEMS = 4,
  parameter int NUM_COINS = 3,
  parameter int COIN_VAL0 = 100,
  parameter int COIN_VAL1 = 500,
  parameter int COIN_VAL2 = 1000,
  parameter int PRICE0 = 400,
  parameter int PRICE1 = 500,
  parameter int PRICE2 = 1000,
  parameter int PRICE3 = 2000,
  parameter int MAX_BALANCE = 10000,
  parameter int TIMEOUT = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  output logic [NUM_ITEMS-1:0]  o_available_item,
  output logic [NUM_ITEMS-1:0]  o_output_item,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic [TOTAL_BITS-1:0] o_current_total,
  output logic                  o_coin_reject,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  localparam int COINS [3] = '{COIN_VAL0, COIN_VAL1, COIN_VAL2};
  localparam int PRICES [4] = '{PRICE0, PRICE1, PRICE2, PRICE3};
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [TOTAL_BITS-1:0] balance, sel_price, coin_val, rem;
  logic [TOTAL_BITS+1:0] sum;
  logic [TW-1:0] timer;
  logic [NUM_ITEMS-1:0] item, sel_hot;
  logic [NUM_COINS-1:0] coin_hot;
  always_comb begin
    sum = {2'b00, balance};
    for (int k = 0; k < NUM_COINS; k++)
      if (i_input_coin[k]) sum = sum + (TOTAL_BITS+2)'(COINS[k]);
    sel_hot = '0;
    sel_price = '0;
    for (int k = NUM_ITEMS - 1; k >= 0; k--)
      if (i_select_item[k]) begin
        sel_hot = '0;
        sel_hot[k] = 1'b1;
        sel_price = TOTAL_BITS'(PRICES[k]);
      end
    coin_hot = '0;
    coin_val = '0;
    for (int k = 0; k < NUM_COINS; k++)
      if (balance >= TOTAL_BITS'(COINS[k])) begin
        coin_hot = '0;
        coin_hot[k] = 1'b1;
        coin_val = TOTAL_BITS'(COINS[k]);
      end
    rem = balance - coin_val;
  end
  assign o_busy = state == DISPENSE || state == CHANGE;
  assign o_current_total = balance;
  assign o_output_item = state == DISPENSE ? item : '0;
  assign o_return_coin = state == CHANGE ? coin_hot : '0;
  for (genvar j = 0; j < NUM_ITEMS; j++) begin : g_avail
    assign o_available_item[j] = !o_busy && balance >= TOTAL_BITS'(PRICES[j]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      balance <= '0;
      timer <= '0;
      item <= '0;
      o_coin_reject <= 1'b0;
    end else begin
      o_coin_reject <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (i_trigger_return) begin
            if (balance != 0) state <= CHANGE;
          end else if (|i_select_item && balance >= sel_price) begin
            balance <= balance - sel_price;
            item <= sel_hot;
            state <= DISPENSE;
          end else if (!(|i_select_item) && |i_input_coin && sum <= (TOTAL_BITS+2)'(MAX_BALANCE)) begin
            balance <= sum[TOTAL_BITS-1:0];
            timer <= TW'(TIMEOUT);
            state <= COLLECT;
          end else begin
            o_coin_reject <= !(|i_select_item) && |i_input_coin;
            if (state == COLLECT) begin
              if (timer <= 1) state <= CHANGE;
              else timer <= timer - 1'b1;
            end
          end
        end
        DISPENSE: begin
          state <= balance != 0 ? COLLECT : IDLE;
          timer <= TW'(TIMEOUT);
          item <= '0;
        end
        CHANGE: begin
          balance <= rem < TOTAL_BITS'(COIN_VAL0) ? '0 : rem;
          if (rem < TOTAL_BITS'(COIN_VAL0)) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: vector table plus timeout, ceiling and reset sequences, scoreboard-checked
module tb_vending_controller;
  typedef struct packed {
    logic [30:0] total;
    logic [3:0]  avail;
    logic [3:0]  out;
    logic [2:0]  ret;
    logic        rej;
    logic        busy;
  } exp_t;
  typedef struct packed {
    logic [2:0] coin;
    logic [3:0] sel;
    logic       ret;
    exp_t       e;
  } vec_t;
  logic clk = 0, reset_n = 0, i_trigger_return = 0;
  logic [2:0] i_input_coin = 0, o_return_coin;
  logic [3:0] i_select_item = 0, o_available_item, o_output_item;
  logic [30:0] o_current_total;
  logic o_coin_reject, o_busy;
  int checks = 0, errors = 0;
  exp_t sbq[$];
  exp_t cur, act;
  logic have = 0;
  vec_t tbl [28];
  vending_controller dut (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin), .i_select_item(i_select_item),
    .i_trigger_return(i_trigger_return), .o_available_item(o_available_item),
    .o_output_item(o_output_item), .o_return_coin(o_return_coin),
    .o_current_total(o_current_total), .o_coin_reject(o_coin_reject), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  assign act = '{o_current_total, o_available_item, o_output_item, o_return_coin, o_coin_reject, o_busy};
  function automatic exp_t e(int t, logic [3:0] a, logic [3:0] o, logic [2:0] rc, logic rj, logic b);
    return '{31'(t), a, o, rc, rj, b};
  endfunction
  function automatic logic [3:0] av(int t);
    return {t >= 2000, t >= 1000, t >= 500, t >= 400};
  endfunction
  function automatic vec_t v(logic [2:0] c, logic [3:0] s, logic r, exp_t x);
    return '{c, s, r, x};
  endfunction
  always @(posedge clk) begin
    have = sbq.size() > 0;
    if (have) cur = sbq.pop_front();
  end
  always @(negedge clk) if (have) begin
    checks++;
    if (act !== cur) begin
      errors++;
      $display("FAIL step @%0t: got total=%0d avail=%b out=%b ret=%b rej=%b busy=%b, required total=%0d avail=%b out=%b ret=%b rej=%b busy=%b",
        $time, act.total, act.avail, act.out, act.ret, act.rej, act.busy,
        cur.total, cur.avail, cur.out, cur.ret, cur.rej, cur.busy);
    end
  end
  task automatic step(logic [2:0] c, logic [3:0] s, logic r, exp_t x);
    i_input_coin = c;
    i_select_item = s;
    i_trigger_return = r;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(exp_t x);
    step(3'b000, 4'b0000, 1'b0, x);
  endtask
  task automatic direct(string name, exp_t x);
    checks++;
    if (act !== x) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, x);
    end
  endtask
  initial begin
    tbl[0]  = v(3'b010, 4'b0000, 0, e(500,  4'b0011, 4'b0000, 3'b000, 0, 0));
    tbl[1]  = v(3'b010, 4'b0000, 0, e(1000, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[2]  = v(3'b000, 4'b0010, 0, e(500,  4'b0000, 4'b0010, 3'b000, 0, 1));
    tbl[3]  = v(3'b000, 4'b0000, 0, e(500,  4'b0011, 4'b0000, 3'b000, 0, 0));
    tbl[4]  = v(3'b000, 4'b0000, 1, e(500,  4'b0000, 4'b0000, 3'b010, 0, 1));
    tbl[5]  = v(3'b000, 4'b0000, 0, e(0,    4'b0000, 4'b0000, 3'b000, 0, 0));
    tbl[6]  = v(3'b100, 4'b0000, 0, e(1000, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[7]  = v(3'b010, 4'b0000, 0, e(1500, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[8]  = v(3'b001, 4'b0000, 0, e(1600, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[9]  = v(3'b001, 4'b0000, 0, e(1700, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[10] = v(3'b000, 4'b0000, 1, e(1700, 4'b0000, 4'b0000, 3'b100, 0, 1));
    tbl[11] = v(3'b000, 4'b0000, 0, e(700,  4'b0000, 4'b0000, 3'b010, 0, 1));
    tbl[12] = v(3'b000, 4'b0000, 0, e(200,  4'b0000, 4'b0000, 3'b001, 0, 1));
    tbl[13] = v(3'b000, 4'b0000, 0, e(100,  4'b0000, 4'b0000, 3'b001, 0, 1));
    tbl[14] = v(3'b000, 4'b0000, 0, e(0,    4'b0000, 4'b0000, 3'b000, 0, 0));
    tbl[15] = v(3'b001, 4'b0000, 0, e(100,  4'b0000, 4'b0000, 3'b000, 0, 0));
    tbl[16] = v(3'b000, 4'b0001, 0, e(100,  4'b0000, 4'b0000, 3'b000, 0, 0));
    tbl[17] = v(3'b010, 4'b0000, 0, e(600,  4'b0011, 4'b0000, 3'b000, 0, 0));
    tbl[18] = v(3'b001, 4'b0001, 0, e(200,  4'b0000, 4'b0001, 3'b000, 0, 1));
    tbl[19] = v(3'b000, 4'b0000, 0, e(200,  4'b0000, 4'b0000, 3'b000, 0, 0));
    tbl[20] = v(3'b111, 4'b0000, 0, e(1800, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[21] = v(3'b000, 4'b0110, 0, e(1300, 4'b0000, 4'b0010, 3'b000, 0, 1));
    tbl[22] = v(3'b000, 4'b0000, 0, e(1300, 4'b0111, 4'b0000, 3'b000, 0, 0));
    tbl[23] = v(3'b000, 4'b0000, 1, e(1300, 4'b0000, 4'b0000, 3'b100, 0, 1));
    tbl[24] = v(3'b000, 4'b0000, 0, e(300,  4'b0000, 4'b0000, 3'b001, 0, 1));
    tbl[25] = v(3'b100, 4'b0000, 0, e(200,  4'b0000, 4'b0000, 3'b001, 0, 1));
    tbl[26] = v(3'b000, 4'b0000, 0, e(100,  4'b0000, 4'b0000, 3'b001, 0, 1));
    tbl[27] = v(3'b000, 4'b0000, 0, e(0,    4'b0000, 4'b0000, 3'b000, 0, 0));
    #1 direct("reset_state", e(0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 28; i++) step(tbl[i].coin, tbl[i].sel, tbl[i].ret, tbl[i].e);
    for (int i = 1; i <= 10; i++) step(3'b100, 0, 0, e(1000 * i, av(1000 * i), 0, 0, 0, 0));
    step(3'b001, 0, 0, e(10000, 4'b1111, 0, 0, 1, 0));
    idle(e(10000, 4'b1111, 0, 0, 0, 0));
    step(0, 0, 1, e(10000, 0, 0, 3'b100, 0, 1));
    for (int i = 1; i < 10; i++) idle(e(10000 - 1000 * i, 0, 0, 3'b100, 0, 1));
    idle(e(0, 0, 0, 0, 0, 0));
    step(3'b100, 0, 0, e(1000, av(1000), 0, 0, 0, 0));
    for (int i = 1; i < 100; i++) idle(e(1000, av(1000), 0, 0, 0, 0));
    idle(e(1000, 0, 0, 3'b100, 0, 1));
    idle(e(0, 0, 0, 0, 0, 0));
    step(3'b100, 0, 0, e(1000, av(1000), 0, 0, 0, 0));
    for (int i = 1; i < 100; i++) idle(e(1000, av(1000), 0, 0, 0, 0));
    step(3'b001, 0, 0, e(1100, av(1100), 0, 0, 0, 0));
    for (int i = 1; i < 100; i++) idle(e(1100, av(1100), 0, 0, 0, 0));
    idle(e(1100, 0, 0, 3'b100, 0, 1));
    idle(e(100, 0, 0, 3'b001, 0, 1));
    idle(e(0, 0, 0, 0, 0, 0));
    step(3'b001, 0, 0, e(100, av(100), 0, 0, 0, 0));
    step(3'b010, 0, 0, e(600, av(600), 0, 0, 0, 0));
    step(3'b100, 0, 0, e(1600, av(1600), 0, 0, 0, 0));
    step(0, 0, 1, e(1600, 0, 0, 3'b100, 0, 1));
    idle(e(600, 0, 0, 3'b010, 0, 1));
    @(negedge clk);
    #1 reset_n = 0;
    #1 direct("async_reset_mid_change", e(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset_n = 1;
    idle(e(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
